// File: rtl/mips_bus_check_pkg.sv
// mips_bus_check_pkg
// Shared definitions for the mips_cpu_bus checker: verdict FSM states,
// failure codes reported on fail_code, and the first-fetch check helper.
package mips_bus_check_pkg;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        RUN   = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [7:0] FC_NONE      = 8'd0;
    localparam logic [7:0] FC_TIMEOUT   = 8'd100;
    localparam logic [7:0] FC_ACTIVE    = 8'd101;
    localparam logic [7:0] FC_RESET_VEC = 8'd102;
    localparam logic [7:0] FC_NOT_READ  = 8'd103;
    localparam logic [7:0] FC_WRITE     = 8'd104;
    localparam logic [7:0] FC_BYTEEN    = 8'd105;
    localparam logic [7:0] FC_V0        = 8'd106;
    localparam logic [7:0] FC_RW_BOTH   = 8'd107;
    localparam logic [7:0] FC_ALIGN     = 8'd108;
    localparam logic [7:0] FC_BE_ZERO   = 8'd109;
    localparam logic [7:0] FC_CHANGED   = 8'd110;
    localparam logic [7:0] FC_MAXWAIT   = 8'd111;

    // First bus cycle after reset must be a full-word instruction fetch from
    // the reset vector; the earliest failing check determines the code.
    function automatic logic [7:0] first_fetch_code(
        input logic        active,
        input logic [31:0] address,
        input logic [31:0] reset_vector,
        input logic        read,
        input logic        write,
        input logic [3:0]  byteenable
    );
        logic [7:0] code;
        if (!active) begin
            code = FC_ACTIVE;
        end else if (address != reset_vector) begin
            code = FC_RESET_VEC;
        end else if (!read) begin
            code = FC_NOT_READ;
        end else if (write) begin
            code = FC_WRITE;
        end else if (byteenable != 4'hF) begin
            code = FC_BYTEEN;
        end else begin
            code = FC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mips_cpu_bus_checker_tracker.sv
// mips_bus_req_tracker
// Remembers the previous bus request and whether it was stalled, and counts
// consecutive stalled cycles of the current request.
// Ports:
//   clk, reset                 clock / async active-high reset
//   address, read, write,
//   byteenable, writedata,
//   waitrequest                observed bus signals
//   changed_under_wait         request differs from the one stalled last cycle
//   wait_exceeded              this stalled cycle is number MAX_WAIT+1 (MAX_WAIT>0)
module mips_bus_req_tracker #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    input  logic        waitrequest,
    output logic        changed_under_wait,
    output logic        wait_exceeded
);

    localparam logic [31:0] WAIT_LIMIT = MAX_WAIT;

    logic        req_s;
    logic        stall_s;
    logic [31:0] prev_address_q, prev_address_d;
    logic        prev_read_q, prev_read_d;
    logic        prev_write_q, prev_write_d;
    logic [3:0]  prev_byteenable_q, prev_byteenable_d;
    logic [31:0] prev_writedata_q, prev_writedata_d;
    logic        prev_stall_q, prev_stall_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign req_s   = read | write;
    assign stall_s = req_s & waitrequest;

    // Next-state for the request snapshot and the stall run length.
    always_comb begin
        prev_address_d    = address;
        prev_read_d       = read;
        prev_write_d      = write;
        prev_byteenable_d = byteenable;
        prev_writedata_d  = writedata;
        prev_stall_d      = stall_s;
        if (stall_s) begin
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = 32'd0;
        end
    end

    // Snapshot and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_address_q    <= 32'd0;
            prev_read_q       <= 1'b0;
            prev_write_q      <= 1'b0;
            prev_byteenable_q <= 4'd0;
            prev_writedata_q  <= 32'd0;
            prev_stall_q      <= 1'b0;
            stall_cnt_q       <= 32'd0;
        end else begin
            prev_address_q    <= prev_address_d;
            prev_read_q       <= prev_read_d;
            prev_write_q      <= prev_write_d;
            prev_byteenable_q <= prev_byteenable_d;
            prev_writedata_q  <= prev_writedata_d;
            prev_stall_q      <= prev_stall_d;
            stall_cnt_q       <= stall_cnt_d;
        end
    end

    // A stalled request must be re-presented unchanged; write data only
    // matters when the held request is a write. stall_cnt_q holds the stalls
    // already seen, so this cycle is stall number stall_cnt_q+1.
    always_comb begin
        changed_under_wait = prev_stall_q &&
            ((address != prev_address_q) || (read != prev_read_q) ||
             (write != prev_write_q) || (byteenable != prev_byteenable_q) ||
             (prev_write_q && (writedata != prev_writedata_q)));
        wait_exceeded = (WAIT_LIMIT != 32'd0) && stall_s && (stall_cnt_q >= WAIT_LIMIT);
    end

endmodule

// File: rtl/mips_cpu_bus_checker.sv
// mips_cpu_bus_checker
// Passive monitor beside a CPU and bus RAM: checks the first fetch, bus
// protocol, stall length, run time and final v0, and reports one sticky verdict.
// Ports:
//   clk, reset                    clock / async active-high reset
//   active, register_v0           CPU status and v0 debug value
//   address, write, read,
//   waitrequest, writedata,
//   byteenable, readdata          observed bus (readdata is not checked)
//   done, pass, fail_code         sticky verdict
//   cycle_count, read_count,
//   write_count                   saturating run statistics
module mips_cpu_bus_checker
    import mips_bus_check_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter logic [31:0] EXPECTED_V0    = 32'h00000000,
    parameter logic        CHECK_V0       = 1'b1,
    parameter int unsigned MAX_WAIT       = 0,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [31:0]      register_v0,
    input  logic [31:0]      address,
    input  logic             write,
    input  logic             read,
    input  logic             waitrequest,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byteenable,
    input  logic [31:0]      readdata,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] write_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       code_s;
    logic [7:0]       proto_code_s;
    logic             req_s;
    logic             changed_under_wait_s;
    logic             wait_exceeded_s;
    logic             readdata_unused_s;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       fail_code_q, fail_code_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] read_count_q, read_count_d;
    logic [CNT_W-1:0] write_count_q, write_count_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign req_s             = read | write;
    assign readdata_unused_s = ^readdata;

    mips_bus_req_tracker #(
        .MAX_WAIT (MAX_WAIT)
    ) u_tracker (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .read               (read),
        .write              (write),
        .byteenable         (byteenable),
        .writedata          (writedata),
        .waitrequest        (waitrequest),
        .changed_under_wait (changed_under_wait_s),
        .wait_exceeded      (wait_exceeded_s)
    );

    // Protocol violation code for this edge; lowest code wins.
    always_comb begin
        if (read && write) begin
            proto_code_s = FC_RW_BOTH;
        end else if (req_s && (address[1:0] != 2'b00)) begin
            proto_code_s = FC_ALIGN;
        end else if (req_s && (byteenable == 4'h0)) begin
            proto_code_s = FC_BE_ZERO;
        end else if (changed_under_wait_s) begin
            proto_code_s = FC_CHANGED;
        end else if (wait_exceeded_s) begin
            proto_code_s = FC_MAXWAIT;
        end else begin
            proto_code_s = FC_NONE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ARMED;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            cycle_count_q <= '0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    // Next state and the failure code that goes with a move to FAIL.
    // In RUN, completion outranks protocol errors, which outrank timeout.
    always_comb begin
        state_d = state_q;
        code_s  = FC_NONE;
        case (state_q)
            ARMED: begin
                code_s = first_fetch_code(active, address, RESET_VECTOR,
                                          read, write, byteenable);
                if (code_s != FC_NONE) begin
                    state_d = FAIL;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!active) begin
                    if (CHECK_V0 && (register_v0 != EXPECTED_V0)) begin
                        state_d = FAIL;
                        code_s  = FC_V0;
                    end else begin
                        state_d = PASS;
                    end
                end else if (proto_code_s != FC_NONE) begin
                    state_d = FAIL;
                    code_s  = proto_code_s;
                end else if (cycle_count_q == TIMEOUT_LAST) begin
                    state_d = FAIL;
                    code_s  = FC_TIMEOUT;
                end else begin
                    state_d = RUN;
                end
            end
            PASS:    state_d = PASS;
            FAIL:    state_d = FAIL;
            default: state_d = ARMED;
        endcase
    end

    // Verdict and counter updates. Counters only move on edges that leave
    // the checker in RUN, so they freeze at the deciding edge.
    always_comb begin
        done_d        = (state_d == PASS) || (state_d == FAIL);
        pass_d        = (state_d == PASS);
        cycle_count_d = cycle_count_q;
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if ((state_d == FAIL) && (state_q != FAIL)) begin
            fail_code_d = code_s;
        end else begin
            fail_code_d = fail_code_q;
        end
        if (state_d == RUN) begin
            if (state_q == RUN) begin
                cycle_count_d = sat_inc(cycle_count_q);
            end else begin
                cycle_count_d = cycle_count_q;
            end
            if (read && !waitrequest) begin
                read_count_d = sat_inc(read_count_q);
            end else begin
                read_count_d = read_count_q;
            end
            if (write && !waitrequest) begin
                write_count_d = sat_inc(write_count_q);
            end else begin
                write_count_d = write_count_q;
            end
        end else begin
            cycle_count_d = cycle_count_q;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign read_count  = read_count_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_mips_cpu_bus_checker.sv
// Bench for mips_cpu_bus_checker: directed bus vectors; each test pushes its
// hand-computed verdict into a queue and a negedge monitor compares it when
// done rises.
module tb_mips_cpu_bus_checker;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        done;
    logic        pass;
    logic [7:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] read_count;
    logic [31:0] write_count;

    mips_cpu_bus_checker #(
        .RESET_VECTOR   (32'hBFC00000),
        .TIMEOUT_CYCLES (50),
        .EXPECTED_V0    (32'd6),
        .CHECK_V0       (1'b1),
        .MAX_WAIT       (3),
        .CNT_W          (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .read_count  (read_count),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pass;
        logic [7:0]  code;
        logic [31:0] cyc;
        logic [31:0] rd;
        logic [31:0] wr;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_pass  = 0;
    int    n_total = 0;
    string cur_test = "reset";
    logic  done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0d (0x%08h), expected %0d (0x%08h)",
                     cur_test, name, act, act, exp, exp);
        end
    endtask

    // Monitor: compares the oldest expected verdict when done first rises.
    always @(negedge clk) begin
        if (reset) begin
            done_seen = 1'b0;
        end else if (done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_verdict", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pass", {31'd0, pass}, {31'd0, mon_e.pass});
                check("fail_code", {24'd0, fail_code}, {24'd0, mon_e.code});
                check("cycle_count", cycle_count, mon_e.cyc);
                check("read_count", read_count, mon_e.rd);
                check("write_count", write_count, mon_e.wr);
            end
        end
    end

    task automatic expect_verdict(input logic p, input logic [7:0] c,
                                  input logic [31:0] cy, input logic [31:0] rd,
                                  input logic [31:0] wr);
        exp_t e;
        e.pass = p;
        e.code = c;
        e.cyc  = cy;
        e.rd   = rd;
        e.wr   = wr;
        exp_q.push_back(e);
    endtask

    // Present one bus cycle, then step past the edge that samples it.
    task automatic drv(input logic act, input logic [31:0] a, input logic rd,
                       input logic wr, input logic [3:0] be, input logic wq,
                       input logic [31:0] v0);
        active      = act;
        address     = a;
        read        = rd;
        write       = wr;
        byteenable  = be;
        waitrequest = wq;
        register_v0 = v0;
        writedata   = a ^ 32'h5A5A0000;
        readdata    = a + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input string name);
        cur_test = name;
        reset = 1'b1;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    task automatic good_fetch();
        drv(1'b1, RV, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
    endtask

    task automatic wait_verdict();
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("verdict_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Small program: stalled fetch, load, store, then active falls with v0.
    task automatic program_run(input logic [31:0] v0);
        good_fetch();
        drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b1, 32'd0);
        drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        drv(1'b1, RV + 32'd8, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        drv(1'b1, 32'h1000, 1'b0, 1'b1, 4'h3, 1'b0, 32'd0);
        drv(1'b1, 32'h1000, 1'b0, 1'b0, 4'hF, 1'b0, 32'd0);
        drv(1'b1, 32'h1000, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'hF, 1'b0, v0);
    endtask

    task automatic first_fetch_case(input string name, input logic act,
                                    input logic [31:0] a, input logic rd,
                                    input logic wr, input logic [3:0] be,
                                    input logic [7:0] code);
        expect_verdict(1'b0, code, 32'd0, 32'd0, 32'd0);
        start_test(name);
        drv(act, a, rd, wr, be, 1'b0, 32'd0);
        wait_verdict();
    endtask

    task automatic protocol_case(input string name, input logic [31:0] a,
                                 input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [7:0] code);
        expect_verdict(1'b0, code, 32'd0, 32'd1, 32'd0);
        start_test(name);
        good_fetch();
        drv(1'b1, a, rd, wr, be, 1'b0, 32'd0);
        wait_verdict();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_fail_code", {24'd0, fail_code}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_read_count", read_count, 32'd0);
        check("rst_write_count", write_count, 32'd0);

        // Compliant program, v0 matches.
        expect_verdict(1'b1, 8'd0, 32'd6, 32'd4, 32'd1);
        start_test("prog_pass");
        program_run(32'd6);
        wait_verdict();
        // Verdict and counters stay put despite later bus garbage.
        drv(1'b1, RV + 32'd1, 1'b1, 1'b1, 4'h0, 1'b1, 32'd0);
        drv(1'b1, RV + 32'd2, 1'b1, 1'b1, 4'h0, 1'b0, 32'd0);
        drv(1'b1, RV + 32'd3, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        check("sticky_done", {31'd0, done}, 32'd1);
        check("sticky_pass", {31'd0, pass}, 32'd1);
        check("sticky_code", {24'd0, fail_code}, 32'd0);
        check("sticky_cycles", cycle_count, 32'd6);
        check("sticky_reads", read_count, 32'd4);

        // Same program, wrong v0.
        expect_verdict(1'b0, 8'd106, 32'd6, 32'd4, 32'd1);
        start_test("prog_v0");
        program_run(32'd7);
        wait_verdict();

        first_fetch_case("ff_inactive", 1'b0, RV, 1'b1, 1'b0, 4'hF, 8'd101);
        first_fetch_case("ff_addr0", 1'b1, 32'd0, 1'b1, 1'b0, 4'hF, 8'd102);
        first_fetch_case("ff_noread", 1'b1, RV, 1'b0, 1'b0, 4'hF, 8'd103);
        first_fetch_case("ff_write", 1'b1, RV, 1'b1, 1'b1, 4'hF, 8'd104);
        first_fetch_case("ff_be", 1'b1, RV, 1'b1, 1'b0, 4'h7, 8'd105);

        protocol_case("rw_both", RV + 32'd4, 1'b1, 1'b1, 4'hF, 8'd107);
        protocol_case("misalign", RV + 32'd6, 1'b1, 1'b0, 4'hF, 8'd108);
        protocol_case("be_zero", 32'h1000, 1'b0, 1'b1, 4'h0, 8'd109);

        // Address change while stalled.
        expect_verdict(1'b0, 8'd110, 32'd1, 32'd1, 32'd0);
        start_test("changed_wait");
        good_fetch();
        drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b1, 32'd0);
        drv(1'b1, RV + 32'd8, 1'b1, 1'b0, 4'hF, 1'b1, 32'd0);
        wait_verdict();

        // Four stalled cycles exceed MAX_WAIT=3.
        expect_verdict(1'b0, 8'd111, 32'd3, 32'd1, 32'd0);
        start_test("wait_4");
        good_fetch();
        repeat (4) drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b1, 32'd0);
        wait_verdict();

        // Three stalled cycles then accept is fine.
        expect_verdict(1'b1, 8'd0, 32'd4, 32'd2, 32'd0);
        start_test("wait_3");
        good_fetch();
        repeat (3) drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b1, 32'd0);
        drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 4'hF, 1'b0, 32'd6);
        wait_verdict();

        // Completion outranks a simultaneous read&write.
        expect_verdict(1'b1, 8'd0, 32'd0, 32'd1, 32'd0);
        start_test("completion_wins");
        good_fetch();
        drv(1'b0, RV + 32'd4, 1'b1, 1'b1, 4'hF, 1'b0, 32'd6);
        wait_verdict();

        // CPU never finishes: timeout on the 50th RUN edge.
        expect_verdict(1'b0, 8'd100, 32'd49, 32'd1, 32'd0);
        start_test("timeout");
        good_fetch();
        repeat (55) drv(1'b1, RV, 1'b0, 1'b0, 4'hF, 1'b0, 32'd0);
        wait_verdict();
        check("timeout_frozen", cycle_count, 32'd49);

        // Async reset clears a standing verdict immediately.
        #2;
        reset = 1'b1;
        #1;
        check("async_done", {31'd0, done}, 32'd0);
        check("async_code", {24'd0, fail_code}, 32'd0);
        check("async_cycles", cycle_count, 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-RUN, then the first-fetch checks apply again.
        cur_test = "midrun_reset";
        reset = 1'b0;
        good_fetch();
        drv(1'b1, RV + 32'd4, 1'b1, 1'b0, 4'hF, 1'b0, 32'd0);
        check("midrun_reads", read_count, 32'd2);
        check("midrun_cycles", cycle_count, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_rst_reads", read_count, 32'd0);
        check("midrun_rst_cycles", cycle_count, 32'd0);
        check("midrun_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        expect_verdict(1'b0, 8'd103, 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        drv(1'b1, RV, 1'b0, 1'b0, 4'hF, 1'b0, 32'd0);
        wait_verdict();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
